quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
Quadrature-encoder front end feeding the mod-n up/down counter stage. It does four things:
- Synchronises and deglitches the two encoder channels.
- Decodes Gray-code transitions in x4 mode.
- Emits a one-cycle step pulse plus a held direction bit (up_down). These form the counter's enable and direction inputs.
- Flags and counts illegal (double-bit) transitions.

Parameters:
SYNC_STAGES, 2, flip-flops per channel in the input synchroniser (legal ≥2).
FILTER_LEN, 4, consecutive cycles a synchronised level must differ from the filtered level before it is accepted (legal ≥1).
ERR_W, 8, width of the saturating illegal-transition counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
enc_a  input  1  encoder channel A, asynchronous.
enc_b  input  1  encoder channel B, asynchronous.
clr_err  input  1  synchronous clear of err and err_count.
step  output  1  one-cycle pulse per valid quadrature transition.
up_down  output  1  direction of the last valid step: 1 = up, 0 = down. Held between steps.
err  output  1  sticky illegal-transition flag.
err_count  output  ERR_W  saturating count of illegal transitions.
busy_init  output  1  high while in INIT state.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Synchroniser flops, filtered levels fa/fb, previous state and filter counters clear to 0.
  - FSM enters INIT; step=0, up_down=1, err=0, err_count=0, busy_init=1.
- Synchroniser: each channel passes through SYNC_STAGES flops; sa/sb denote the outputs.
- FSM states:
  - INIT: an init counter runs for SYNC_STAGES cycles after reset deassertion. On the final INIT cycle, fa<=sa, fb<=sb and prev<={sa,sb}, then go to RUN. No step and no err is generated in INIT; busy_init=1.
  - RUN: normal decode; busy_init=0. Only rst leaves RUN.
- Filter (per channel, RUN only):
  - While sX != fX, the channel's counter increments.
  - On the edge where the counter would reach FILTER_LEN, fX<=sX and the counter clears.
  - If sX == fX in any cycle, the counter clears (glitch rejected).
- Decode (RUN), comparing the new {fa,fb} with prev, registered:
  - Up sequence: 00→01→11→10→00. Forward step: step=1 next cycle, up_down<=1.
  - Reverse sequence: step=1 next cycle, up_down<=0.
  - Both bits change in the same cycle (00↔11 or 01↔10): illegal. No step, up_down unchanged, err<=1, err_count<=err_count+1, saturating at 2^ERR_W−1.
  - No change: step=0.
  - prev<={fa,fb} every cycle.
- Latency: a clean level change on one pin produces step high in the cycle after clock edge SYNC_STAGES+FILTER_LEN+1, counted from the first edge that samples the new level (edge 1). Defaults: step is high after edge 7.
- Throughput: at most one step per cycle. Back-to-back steps are legal if filtered levels change on consecutive cycles.
- clr_err=1 clears err and err_count next cycle. If an illegal transition is detected in the same cycle, the error wins: err=1, err_count=1.
- rst asserted mid-operation: all state returns to reset values on that edge, and no step is emitted in that cycle or the next. The step pulse is never stretched.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, pins held at {a,b}=11 → busy_init=1 for 2 cycles then 0; no step and err=0 throughout (INIT absorbs the initial level).
2. From 00, drive 01,11,10,00 with each level held 10 cycles → four step pulses, each 1 cycle wide, up_down=1. First step is high after edge 7 from the first sample of 01.
3. From 00, drive 10,11,01,00 → four steps with up_down=0. Then a single forward transition → up_down returns to 1 with that step.
4. Glitch on enc_a of 3 cycles at FILTER_LEN=4 → fa unchanged, no step, no err. A 4-cycle pulse → two steps (up then down).
5. Jump 00→11 on both pins in the same cycle → no step, err=1, err_count=1. Repeat 300 times with ERR_W=8 → err_count saturates at 255. clr_err together with a new illegal event → err=1, err_count=1.
6. Assert rst while a step pulse is due → step stays 0, up_down=1, err_count=0; re-enters INIT for 2 cycles.

Source files
------------

// File: rtl/quad_step_decoder.sv
// quad_step_decoder
// Quadrature encoder front end for the mod-n up/down counter stage.
// - Each channel is synchronised, then deglitched by a per-channel filter.
// - x4 Gray-code decoding produces a one-cycle step pulse and a held
//   direction bit (up_down).
// - Double-bit (illegal) transitions set a sticky error flag and bump a
//   saturating error counter.
// Every output comes straight from a flop.

module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr_err,
    output logic             step,
    output logic             up_down,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic             busy_init
);

    // Counter widths sized so the terminal values always fit.
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int ICW = $clog2(SYNC_STAGES + 1);

    localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [ICW-1:0]   INIT_LAST = ICW'(SYNC_STAGES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // State registers and their next-state values.
    state_t             state_q, state_d;
    logic [ICW-1:0]     init_cnt_q, init_cnt_d;
    logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
    logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
    logic               fa_q, fa_d;
    logic               fb_q, fb_d;
    logic [FCW-1:0]     fcnt_a_q, fcnt_a_d;
    logic [FCW-1:0]     fcnt_b_q, fcnt_b_d;
    logic [1:0]         prev_q, prev_d;
    logic               step_q, step_d;
    logic               up_down_q, up_down_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               busy_init_q, busy_init_d;

    // Filter and decode intermediates.
    logic               sa, sb;
    logic               fa_accept, fb_accept;
    logic [FCW-1:0]     fcnt_a_next, fcnt_b_next;
    logic [1:0]         cur_ab;
    logic               is_fwd, is_rev, is_illegal;
    logic               err_base;
    logic [ERR_W-1:0]   err_count_base;

    // Next Gray-code state in the up direction: 00->01->11->10->00.
    function automatic logic [1:0] fwd_of(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    // Next Gray-code state in the down direction: 00->10->11->01->00.
    function automatic logic [1:0] rev_of(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            2'b00:   n = 2'b10;
            2'b10:   n = 2'b11;
            2'b11:   n = 2'b01;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    assign sa = sync_a_q[SYNC_STAGES-1];
    assign sb = sync_b_q[SYNC_STAGES-1];

    // Shift each asynchronous channel through its synchroniser chain.
    always_comb begin
        sync_a_d = {sync_a_q[SYNC_STAGES-2:0], enc_a};
        sync_b_d = {sync_b_q[SYNC_STAGES-2:0], enc_b};
    end

    // Channel A filter: a new level is accepted only after it has differed
    // from the filtered level for FILTER_LEN consecutive cycles.
    always_comb begin
        fa_accept   = 1'b0;
        fcnt_a_next = '0;
        if (sa != fa_q) begin
            if (fcnt_a_q == FILT_LAST) begin
                fa_accept = 1'b1;
            end else begin
                fcnt_a_next = fcnt_a_q + 1'b1;
            end
        end
    end

    // Channel B filter, identical to channel A.
    always_comb begin
        fb_accept   = 1'b0;
        fcnt_b_next = '0;
        if (sb != fb_q) begin
            if (fcnt_b_q == FILT_LAST) begin
                fb_accept = 1'b1;
            end else begin
                fcnt_b_next = fcnt_b_q + 1'b1;
            end
        end
    end

    // Classify the filtered-level change against the previous filtered state.
    always_comb begin
        cur_ab     = {fa_q, fb_q};
        is_fwd     = (cur_ab == fwd_of(prev_q));
        is_rev     = (cur_ab == rev_of(prev_q));
        is_illegal = (cur_ab == ~prev_q);
    end

    // Error flag/counter after a clear request; an illegal event in the same
    // cycle is then applied on top of the cleared value, so the error wins.
    always_comb begin
        err_base       = clr_err ? 1'b0 : err_q;
        err_count_base = clr_err ? '0 : err_count_q;
    end

    // Main next-state logic for the INIT/RUN controller, filters and decoder.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        fa_d        = fa_q;
        fb_d        = fb_q;
        fcnt_a_d    = '0;
        fcnt_b_d    = '0;
        prev_d      = prev_q;
        step_d      = 1'b0;
        up_down_d   = up_down_q;
        err_d       = err_base;
        err_count_d = err_count_base;
        busy_init_d = busy_init_q;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    // Seed the filtered levels with the value the synchroniser
                    // output takes on this edge, so a level already present
                    // at reset is absorbed instead of decoded as motion.
                    fa_d        = sync_a_q[SYNC_STAGES-2];
                    fb_d        = sync_b_q[SYNC_STAGES-2];
                    prev_d      = {sync_a_q[SYNC_STAGES-2], sync_b_q[SYNC_STAGES-2]};
                    init_cnt_d  = '0;
                    state_d     = ST_RUN;
                    busy_init_d = 1'b0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end

            default: begin
                fcnt_a_d = fcnt_a_next;
                fcnt_b_d = fcnt_b_next;
                if (fa_accept) begin
                    fa_d = sa;
                end
                if (fb_accept) begin
                    fb_d = sb;
                end

                prev_d = cur_ab;
                if (is_fwd) begin
                    step_d    = 1'b1;
                    up_down_d = 1'b1;
                end else if (is_rev) begin
                    step_d    = 1'b1;
                    up_down_d = 1'b0;
                end else if (is_illegal) begin
                    err_d = 1'b1;
                    if (err_count_base != ERR_MAX) begin
                        err_count_d = err_count_base + 1'b1;
                    end
                end
            end
        endcase
    end

    // Register all state; synchronous reset returns everything to INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            sync_a_q    <= '0;
            sync_b_q    <= '0;
            fa_q        <= 1'b0;
            fb_q        <= 1'b0;
            fcnt_a_q    <= '0;
            fcnt_b_q    <= '0;
            prev_q      <= 2'b00;
            step_q      <= 1'b0;
            up_down_q   <= 1'b1;
            err_q       <= 1'b0;
            err_count_q <= '0;
            busy_init_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            sync_a_q    <= sync_a_d;
            sync_b_q    <= sync_b_d;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            fcnt_a_q    <= fcnt_a_d;
            fcnt_b_q    <= fcnt_b_d;
            prev_q      <= prev_d;
            step_q      <= step_d;
            up_down_q   <= up_down_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            busy_init_q <= busy_init_d;
        end
    end

    assign step      = step_q;
    assign up_down   = up_down_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign busy_init = busy_init_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder
// Directed testbench for quad_step_decoder using default parameters
// (SYNC_STAGES=2, FILTER_LEN=4, ERR_W=8).

module tb_quad_step_decoder;

    logic       clk;
    logic       rst;
    logic       enc_a;
    logic       enc_b;
    logic       clr_err;
    logic       step;
    logic       up_down;
    logic       err;
    logic [7:0] err_count;
    logic       busy_init;

    int compared;
    int mismatched;

    // Step monitor, updated once per sampled cycle.
    int         step_cnt;
    int         consec;
    logic       prev_step;
    logic [7:0] dir_hist;

    quad_step_decoder #(
        .SYNC_STAGES(2),
        .FILTER_LEN (4),
        .ERR_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .clr_err  (clr_err),
        .step     (step),
        .up_down  (up_down),
        .err      (err),
        .err_count(err_count),
        .busy_init(busy_init)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge, sample 1 time unit later and log step pulses.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (step === 1'b1) begin
            step_cnt++;
            dir_hist = {dir_hist[6:0], up_down};
            if (prev_step) consec++;
        end
        prev_step = step;
    endtask

    task automatic clear_monitor();
        step_cnt  = 0;
        consec    = 0;
        prev_step = 1'b0;
        dir_hist  = '0;
    endtask

    // Drive a pin level at the falling edge and hold it for n cycles.
    task automatic applyStimulus(input logic a, input logic b, input int n);
        @(negedge clk);
        enc_a = a;
        enc_b = b;
        repeat (n) cycle();
    endtask

    // Reset with the given pin levels, then let INIT complete.
    task automatic do_reset(input logic a, input logic b);
        @(negedge clk);
        enc_a = a;
        enc_b = b;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) cycle();
        clear_monitor();
    endtask

    // Reset with pins at 11: INIT lasts 2 cycles and absorbs the level.
    task automatic test_reset();
        @(negedge clk);
        enc_a = 1'b1;
        enc_b = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (step !== 1'b0 || up_down !== 1'b1 || err !== 1'b0 || err_count !== 8'd0 || busy_init !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_values: got step=%0b up_down=%0b err=%0b err_count=%0d busy_init=%0b expected 0 1 0 0 1",
                     step, up_down, err, err_count, busy_init);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_monitor();
        cycle();
        compared++;
        if (busy_init !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL init_busy_1: got %0b expected 1", busy_init);
        end
        cycle();
        compared++;
        if (busy_init !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL init_busy_2: got %0b expected 0", busy_init);
        end
        repeat (20) cycle();
        compared++;
        if (step_cnt !== 0 || err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL init_absorb: got steps=%0d err=%0b expected 0 0", step_cnt, err);
        end
    endtask

    // Forward sequence 00->01->11->10->00 with exact first-step latency.
    task automatic test_forward();
        do_reset(1'b0, 1'b0);
        @(negedge clk);
        enc_a = 1'b0;
        enc_b = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i == 6) begin
                compared++;
                if (step !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL fwd_latency_e6: got step=%0b expected 0", step);
                end
            end
            if (i == 7) begin
                compared++;
                if (step !== 1'b1 || up_down !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL fwd_latency_e7: got step=%0b up_down=%0b expected 1 1", step, up_down);
                end
            end
            if (i == 8) begin
                compared++;
                if (step !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL fwd_width_e8: got step=%0b expected 0", step);
                end
            end
        end
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
        compared++;
        if (step_cnt !== 4 || consec !== 0 || dir_hist[3:0] !== 4'b1111 || err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fwd_sequence: got steps=%0d consec=%0d dirs=%b err=%0b expected 4 0 1111 0",
                     step_cnt, consec, dir_hist[3:0], err);
        end
    endtask

    // Reverse sequence 00->10->11->01->00, then one forward step.
    task automatic test_reverse();
        clear_monitor();
        applyStimulus(1'b1, 1'b0, 10);
        compared++;
        if (step_cnt !== 1 || up_down !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rev_first: got steps=%0d up_down=%0b expected 1 0", step_cnt, up_down);
        end
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 10);
        compared++;
        if (step_cnt !== 4 || dir_hist[3:0] !== 4'b0000 || up_down !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rev_sequence: got steps=%0d dirs=%b up_down=%0b expected 4 0000 0",
                     step_cnt, dir_hist[3:0], up_down);
        end
        applyStimulus(1'b0, 1'b1, 10);
        compared++;
        if (step_cnt !== 5 || up_down !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rev_then_fwd: got steps=%0d up_down=%0b expected 5 1", step_cnt, up_down);
        end
    endtask

    // From 01: a 3-cycle pulse on A is rejected, a 4-cycle one gives up then down.
    task automatic test_glitch();
        clear_monitor();
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 15);
        compared++;
        if (step_cnt !== 0 || err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL glitch_3cyc: got steps=%0d err=%0b expected 0 0", step_cnt, err);
        end
        applyStimulus(1'b1, 1'b1, 4);
        applyStimulus(1'b0, 1'b1, 15);
        compared++;
        if (step_cnt !== 2 || dir_hist[1:0] !== 2'b10 || err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL glitch_4cyc: got steps=%0d dirs=%b err=%0b expected 2 10 0",
                     step_cnt, dir_hist[1:0], err);
        end
    endtask

    // Double-bit jumps: error flag, saturating count, clear vs new error.
    task automatic test_illegal();
        do_reset(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 12);
        compared++;
        if (step_cnt !== 0 || err !== 1'b1 || err_count !== 8'd1 || up_down !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL illegal_first: got steps=%0d err=%0b err_count=%0d up_down=%0b expected 0 1 1 1",
                     step_cnt, err, err_count, up_down);
        end
        for (int k = 2; k <= 300; k++) begin
            logic lvl;
            lvl = (k % 2 == 1) ? 1'b1 : 1'b0;
            applyStimulus(lvl, lvl, 8);
            if (k == 254) begin
                compared++;
                if (err_count !== 8'd254) begin
                    mismatched++;
                    $display("[TB] FAIL illegal_count_254: got %0d expected 254", err_count);
                end
            end
        end
        compared++;
        if (err_count !== 8'd255 || err !== 1'b1 || step_cnt !== 0) begin
            mismatched++;
            $display("[TB] FAIL illegal_saturate: got err_count=%0d err=%0b steps=%0d expected 255 1 0",
                     err_count, err, step_cnt);
        end
        // Pins now at 00; jump to 11 and assert clr_err on the decode edge.
        @(negedge clk);
        enc_a = 1'b1;
        enc_b = 1'b1;
        repeat (6) cycle();
        @(negedge clk);
        clr_err = 1'b1;
        cycle();
        compared++;
        if (err !== 1'b1 || err_count !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL clr_vs_error: got err=%0b err_count=%0d expected 1 1", err, err_count);
        end
        @(negedge clk);
        clr_err = 1'b0;
        repeat (4) cycle();
    endtask

    // Reset arriving on the edge a step is due: no step, state back to INIT.
    task automatic test_reset_mid();
        clear_monitor();
        applyStimulus(1'b0, 1'b1, 10);
        compared++;
        if (step_cnt !== 1 || up_down !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_setup: got steps=%0d up_down=%0b expected 1 0", step_cnt, up_down);
        end
        clear_monitor();
        @(negedge clk);
        enc_a = 1'b0;
        enc_b = 1'b0;
        repeat (6) cycle();
        @(negedge clk);
        rst = 1'b1;
        cycle();
        compared++;
        if (step !== 1'b0 || up_down !== 1'b1 || err_count !== 8'd0 || err !== 1'b0 || busy_init !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_edge: got step=%0b up_down=%0b err_count=%0d err=%0b busy=%0b expected 0 1 0 0 1",
                     step, up_down, err_count, err, busy_init);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle();
        compared++;
        if (step !== 1'b0 || busy_init !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_next: got step=%0b busy=%0b expected 0 1", step, busy_init);
        end
        cycle();
        compared++;
        if (busy_init !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_init_end: got busy=%0b expected 0", busy_init);
        end
        repeat (15) cycle();
        compared++;
        if (step_cnt !== 0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_nostep: got steps=%0d expected 0", step_cnt);
        end
    endtask

    // clr_err on its own clears flag and counter.
    task automatic test_clear();
        applyStimulus(1'b1, 1'b1, 10);
        compared++;
        if (err !== 1'b1 || err_count !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL clear_setup: got err=%0b err_count=%0d expected 1 1", err, err_count);
        end
        @(negedge clk);
        clr_err = 1'b1;
        cycle();
        compared++;
        if (err !== 1'b0 || err_count !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL clear_only: got err=%0b err_count=%0d expected 0 0", err, err_count);
        end
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // B then A one cycle apart: filtered levels change on consecutive edges.
    task automatic test_back_to_back();
        do_reset(1'b0, 1'b0);
        @(negedge clk);
        enc_b = 1'b1;
        cycle();
        @(negedge clk);
        enc_a = 1'b1;
        for (int i = 2; i <= 12; i++) begin
            cycle();
            if (i == 7 || i == 8) begin
                compared++;
                if (step !== 1'b1 || up_down !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_edge%0d: got step=%0b up_down=%0b expected 1 1", i, step, up_down);
                end
            end
            if (i == 9) begin
                compared++;
                if (step !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_edge9: got step=%0b expected 0", step);
                end
            end
        end
        compared++;
        if (step_cnt !== 2 || consec !== 1 || err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_total: got steps=%0d consec=%0d err=%0b expected 2 1 0", step_cnt, consec, err);
        end
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        enc_a      = 1'b1;
        enc_b      = 1'b1;
        clr_err    = 1'b0;
        clear_monitor();

        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_reset_mid();
        test_clear();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
